// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the iterative AES datapath units.
//   AES_BLOCK_W / AES_BYTE_W / AES_NBYTES : block geometry
//   aes_iter_state_e : IDLE/SUB/HOLD encoding used by every iterative unit
//   byte_lsb / get_byte / put_byte : byte-indexed access with byte0 at the
//                                    most-significant end of the block
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

    typedef enum logic [1:0] {
        AES_ST_IDLE = 2'd0,
        AES_ST_SUB  = 2'd1,
        AES_ST_HOLD = 2'd2
    } aes_iter_state_e;

    // Byte 0 lives in [127:120], byte 15 in [7:0].
    function automatic int byte_lsb(input int idx);
        return AES_BLOCK_W - AES_BYTE_W * (idx + 1);
    endfunction

    function automatic aes_byte_t get_byte(input aes_block_t blk, input int idx);
        return blk[byte_lsb(idx) +: AES_BYTE_W];
    endfunction

    function automatic aes_block_t put_byte(input aes_block_t blk, input int idx,
                                            input aes_byte_t val);
        aes_block_t res;
        res = blk;
        res[byte_lsb(idx) +: AES_BYTE_W] = val;
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_sbox_unit_if.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox_unit_if
// Valid/ready bus of the inverse-SubBytes unit: one input stream carrying the
// state after InvShiftRows, one output stream towards AddRoundKey.
//   master : upstream/downstream side (drives in_valid, in_block, out_ready)
//   slave  : the substitution unit (drives in_ready, out_valid, out_block)
// ---------------------------------------------------------------------------
interface aes_inv_sbox_unit_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_block_t in_block;
    logic       out_valid;
    logic       out_ready;
    aes_block_t out_block;

    modport master (
        output in_valid, in_block, out_ready,
        input  in_ready, out_valid, out_block
    );

    modport slave (
        input  in_valid, in_block, out_ready,
        output in_ready, out_valid, out_block
    );

endinterface

// File: rtl/aes_inv_sbox_rom.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox_rom
// Purely combinational AES inverse S-box, one byte.
//   sub_byte : substituted byte coming from the cipher state
//   inv_byte : InvSbox(sub_byte)
// ---------------------------------------------------------------------------
module aes_inv_sbox_rom (
    input  logic [7:0] sub_byte,
    output logic [7:0] inv_byte
);

    always_comb begin
        inv_byte = 8'h00;
        case (sub_byte)
            8'h00: inv_byte = 8'h52; 8'h01: inv_byte = 8'h09; 8'h02: inv_byte = 8'h6a; 8'h03: inv_byte = 8'hd5; 8'h04: inv_byte = 8'h30; 8'h05: inv_byte = 8'h36; 8'h06: inv_byte = 8'ha5; 8'h07: inv_byte = 8'h38;
            8'h08: inv_byte = 8'hbf; 8'h09: inv_byte = 8'h40; 8'h0a: inv_byte = 8'ha3; 8'h0b: inv_byte = 8'h9e; 8'h0c: inv_byte = 8'h81; 8'h0d: inv_byte = 8'hf3; 8'h0e: inv_byte = 8'hd7; 8'h0f: inv_byte = 8'hfb;
            8'h10: inv_byte = 8'h7c; 8'h11: inv_byte = 8'he3; 8'h12: inv_byte = 8'h39; 8'h13: inv_byte = 8'h82; 8'h14: inv_byte = 8'h9b; 8'h15: inv_byte = 8'h2f; 8'h16: inv_byte = 8'hff; 8'h17: inv_byte = 8'h87;
            8'h18: inv_byte = 8'h34; 8'h19: inv_byte = 8'h8e; 8'h1a: inv_byte = 8'h43; 8'h1b: inv_byte = 8'h44; 8'h1c: inv_byte = 8'hc4; 8'h1d: inv_byte = 8'hde; 8'h1e: inv_byte = 8'he9; 8'h1f: inv_byte = 8'hcb;
            8'h20: inv_byte = 8'h54; 8'h21: inv_byte = 8'h7b; 8'h22: inv_byte = 8'h94; 8'h23: inv_byte = 8'h32; 8'h24: inv_byte = 8'ha6; 8'h25: inv_byte = 8'hc2; 8'h26: inv_byte = 8'h23; 8'h27: inv_byte = 8'h3d;
            8'h28: inv_byte = 8'hee; 8'h29: inv_byte = 8'h4c; 8'h2a: inv_byte = 8'h95; 8'h2b: inv_byte = 8'h0b; 8'h2c: inv_byte = 8'h42; 8'h2d: inv_byte = 8'hfa; 8'h2e: inv_byte = 8'hc3; 8'h2f: inv_byte = 8'h4e;
            8'h30: inv_byte = 8'h08; 8'h31: inv_byte = 8'h2e; 8'h32: inv_byte = 8'ha1; 8'h33: inv_byte = 8'h66; 8'h34: inv_byte = 8'h28; 8'h35: inv_byte = 8'hd9; 8'h36: inv_byte = 8'h24; 8'h37: inv_byte = 8'hb2;
            8'h38: inv_byte = 8'h76; 8'h39: inv_byte = 8'h5b; 8'h3a: inv_byte = 8'ha2; 8'h3b: inv_byte = 8'h49; 8'h3c: inv_byte = 8'h6d; 8'h3d: inv_byte = 8'h8b; 8'h3e: inv_byte = 8'hd1; 8'h3f: inv_byte = 8'h25;
            8'h40: inv_byte = 8'h72; 8'h41: inv_byte = 8'hf8; 8'h42: inv_byte = 8'hf6; 8'h43: inv_byte = 8'h64; 8'h44: inv_byte = 8'h86; 8'h45: inv_byte = 8'h68; 8'h46: inv_byte = 8'h98; 8'h47: inv_byte = 8'h16;
            8'h48: inv_byte = 8'hd4; 8'h49: inv_byte = 8'ha4; 8'h4a: inv_byte = 8'h5c; 8'h4b: inv_byte = 8'hcc; 8'h4c: inv_byte = 8'h5d; 8'h4d: inv_byte = 8'h65; 8'h4e: inv_byte = 8'hb6; 8'h4f: inv_byte = 8'h92;
            8'h50: inv_byte = 8'h6c; 8'h51: inv_byte = 8'h70; 8'h52: inv_byte = 8'h48; 8'h53: inv_byte = 8'h50; 8'h54: inv_byte = 8'hfd; 8'h55: inv_byte = 8'hed; 8'h56: inv_byte = 8'hb9; 8'h57: inv_byte = 8'hda;
            8'h58: inv_byte = 8'h5e; 8'h59: inv_byte = 8'h15; 8'h5a: inv_byte = 8'h46; 8'h5b: inv_byte = 8'h57; 8'h5c: inv_byte = 8'ha7; 8'h5d: inv_byte = 8'h8d; 8'h5e: inv_byte = 8'h9d; 8'h5f: inv_byte = 8'h84;
            8'h60: inv_byte = 8'h90; 8'h61: inv_byte = 8'hd8; 8'h62: inv_byte = 8'hab; 8'h63: inv_byte = 8'h00; 8'h64: inv_byte = 8'h8c; 8'h65: inv_byte = 8'hbc; 8'h66: inv_byte = 8'hd3; 8'h67: inv_byte = 8'h0a;
            8'h68: inv_byte = 8'hf7; 8'h69: inv_byte = 8'he4; 8'h6a: inv_byte = 8'h58; 8'h6b: inv_byte = 8'h05; 8'h6c: inv_byte = 8'hb8; 8'h6d: inv_byte = 8'hb3; 8'h6e: inv_byte = 8'h45; 8'h6f: inv_byte = 8'h06;
            8'h70: inv_byte = 8'hd0; 8'h71: inv_byte = 8'h2c; 8'h72: inv_byte = 8'h1e; 8'h73: inv_byte = 8'h8f; 8'h74: inv_byte = 8'hca; 8'h75: inv_byte = 8'h3f; 8'h76: inv_byte = 8'h0f; 8'h77: inv_byte = 8'h02;
            8'h78: inv_byte = 8'hc1; 8'h79: inv_byte = 8'haf; 8'h7a: inv_byte = 8'hbd; 8'h7b: inv_byte = 8'h03; 8'h7c: inv_byte = 8'h01; 8'h7d: inv_byte = 8'h13; 8'h7e: inv_byte = 8'h8a; 8'h7f: inv_byte = 8'h6b;
            8'h80: inv_byte = 8'h3a; 8'h81: inv_byte = 8'h91; 8'h82: inv_byte = 8'h11; 8'h83: inv_byte = 8'h41; 8'h84: inv_byte = 8'h4f; 8'h85: inv_byte = 8'h67; 8'h86: inv_byte = 8'hdc; 8'h87: inv_byte = 8'hea;
            8'h88: inv_byte = 8'h97; 8'h89: inv_byte = 8'hf2; 8'h8a: inv_byte = 8'hcf; 8'h8b: inv_byte = 8'hce; 8'h8c: inv_byte = 8'hf0; 8'h8d: inv_byte = 8'hb4; 8'h8e: inv_byte = 8'he6; 8'h8f: inv_byte = 8'h73;
            8'h90: inv_byte = 8'h96; 8'h91: inv_byte = 8'hac; 8'h92: inv_byte = 8'h74; 8'h93: inv_byte = 8'h22; 8'h94: inv_byte = 8'he7; 8'h95: inv_byte = 8'had; 8'h96: inv_byte = 8'h35; 8'h97: inv_byte = 8'h85;
            8'h98: inv_byte = 8'he2; 8'h99: inv_byte = 8'hf9; 8'h9a: inv_byte = 8'h37; 8'h9b: inv_byte = 8'he8; 8'h9c: inv_byte = 8'h1c; 8'h9d: inv_byte = 8'h75; 8'h9e: inv_byte = 8'hdf; 8'h9f: inv_byte = 8'h6e;
            8'ha0: inv_byte = 8'h47; 8'ha1: inv_byte = 8'hf1; 8'ha2: inv_byte = 8'h1a; 8'ha3: inv_byte = 8'h71; 8'ha4: inv_byte = 8'h1d; 8'ha5: inv_byte = 8'h29; 8'ha6: inv_byte = 8'hc5; 8'ha7: inv_byte = 8'h89;
            8'ha8: inv_byte = 8'h6f; 8'ha9: inv_byte = 8'hb7; 8'haa: inv_byte = 8'h62; 8'hab: inv_byte = 8'h0e; 8'hac: inv_byte = 8'haa; 8'had: inv_byte = 8'h18; 8'hae: inv_byte = 8'hbe; 8'haf: inv_byte = 8'h1b;
            8'hb0: inv_byte = 8'hfc; 8'hb1: inv_byte = 8'h56; 8'hb2: inv_byte = 8'h3e; 8'hb3: inv_byte = 8'h4b; 8'hb4: inv_byte = 8'hc6; 8'hb5: inv_byte = 8'hd2; 8'hb6: inv_byte = 8'h79; 8'hb7: inv_byte = 8'h20;
            8'hb8: inv_byte = 8'h9a; 8'hb9: inv_byte = 8'hdb; 8'hba: inv_byte = 8'hc0; 8'hbb: inv_byte = 8'hfe; 8'hbc: inv_byte = 8'h78; 8'hbd: inv_byte = 8'hcd; 8'hbe: inv_byte = 8'h5a; 8'hbf: inv_byte = 8'hf4;
            8'hc0: inv_byte = 8'h1f; 8'hc1: inv_byte = 8'hdd; 8'hc2: inv_byte = 8'ha8; 8'hc3: inv_byte = 8'h33; 8'hc4: inv_byte = 8'h88; 8'hc5: inv_byte = 8'h07; 8'hc6: inv_byte = 8'hc7; 8'hc7: inv_byte = 8'h31;
            8'hc8: inv_byte = 8'hb1; 8'hc9: inv_byte = 8'h12; 8'hca: inv_byte = 8'h10; 8'hcb: inv_byte = 8'h59; 8'hcc: inv_byte = 8'h27; 8'hcd: inv_byte = 8'h80; 8'hce: inv_byte = 8'hec; 8'hcf: inv_byte = 8'h5f;
            8'hd0: inv_byte = 8'h60; 8'hd1: inv_byte = 8'h51; 8'hd2: inv_byte = 8'h7f; 8'hd3: inv_byte = 8'ha9; 8'hd4: inv_byte = 8'h19; 8'hd5: inv_byte = 8'hb5; 8'hd6: inv_byte = 8'h4a; 8'hd7: inv_byte = 8'h0d;
            8'hd8: inv_byte = 8'h2d; 8'hd9: inv_byte = 8'he5; 8'hda: inv_byte = 8'h7a; 8'hdb: inv_byte = 8'h9f; 8'hdc: inv_byte = 8'h93; 8'hdd: inv_byte = 8'hc9; 8'hde: inv_byte = 8'h9c; 8'hdf: inv_byte = 8'hef;
            8'he0: inv_byte = 8'ha0; 8'he1: inv_byte = 8'he0; 8'he2: inv_byte = 8'h3b; 8'he3: inv_byte = 8'h4d; 8'he4: inv_byte = 8'hae; 8'he5: inv_byte = 8'h2a; 8'he6: inv_byte = 8'hf5; 8'he7: inv_byte = 8'hb0;
            8'he8: inv_byte = 8'hc8; 8'he9: inv_byte = 8'heb; 8'hea: inv_byte = 8'hbb; 8'heb: inv_byte = 8'h3c; 8'hec: inv_byte = 8'h83; 8'hed: inv_byte = 8'h53; 8'hee: inv_byte = 8'h99; 8'hef: inv_byte = 8'h61;
            8'hf0: inv_byte = 8'h17; 8'hf1: inv_byte = 8'h2b; 8'hf2: inv_byte = 8'h04; 8'hf3: inv_byte = 8'h7e; 8'hf4: inv_byte = 8'hba; 8'hf5: inv_byte = 8'h77; 8'hf6: inv_byte = 8'hd6; 8'hf7: inv_byte = 8'h26;
            8'hf8: inv_byte = 8'he1; 8'hf9: inv_byte = 8'h69; 8'hfa: inv_byte = 8'h14; 8'hfb: inv_byte = 8'h63; 8'hfc: inv_byte = 8'h55; 8'hfd: inv_byte = 8'h21; 8'hfe: inv_byte = 8'h0c; 8'hff: inv_byte = 8'h7d;
        endcase
    end

endmodule

// File: rtl/aes_inv_sbox_unit.sv
// ---------------------------------------------------------------------------
// aes_inv_sbox_unit
// Iterative inverse-SubBytes engine: captures one 128-bit state, substitutes
// LANES bytes per clock (byte0 first) and presents the finished block until
// the consumer takes it. One block in flight; a new block can be captured in
// the same cycle the finished one is handed off.
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : valid/ready input (in_*) and output (out_*) streams, slave side
//   busy     : high while substituting (SUB) or holding a result (HOLD)
// Parameter LANES (1,2,4,8,16): bytes per clock; NCYC = 16/LANES clocks per block.
// ---------------------------------------------------------------------------
module aes_inv_sbox_unit
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_inv_sbox_unit_if.slave  bus,
    output logic                busy
);

    localparam int NCYC  = AES_NBYTES / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
        $error("aes_inv_sbox_unit: LANES must be 1, 2, 4, 8 or 16");
    end

    aes_iter_state_e  state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    aes_block_t       work, work_next;
    logic             accept;

    aes_byte_t lane_sub [LANES];
    aes_byte_t lane_inv [LANES];

    // The group addressed by cnt feeds all lanes; the ROMs are shared by every
    // group, so the lane count sets the area/latency trade-off.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_sub[l] = get_byte(work, int'(cnt) * LANES + l);

        aes_inv_sbox_rom u_rom (
            .sub_byte (lane_sub[l]),
            .inv_byte (lane_inv[l])
        );
    end

    always_comb begin
        // NOTE: every output of this block gets a default before the case, so
        // no path leaves a signal unassigned and no latch is inferred.
        state_next    = state;
        cnt_next      = cnt;
        work_next     = work;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_block = '0;
        busy          = 1'b0;

        case (state)
            AES_ST_IDLE: begin
                bus.in_ready = 1'b1;
            end

            AES_ST_SUB: begin
                busy = 1'b1;
                for (int l = 0; l < LANES; l++) begin
                    work_next = put_byte(work_next, int'(cnt) * LANES + l, lane_inv[l]);
                end
                if (cnt == CNT_LAST) begin
                    state_next = AES_ST_HOLD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            AES_ST_HOLD: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_block = work;
                // Hand-off and next capture share one edge: no bubble.
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    state_next = AES_ST_IDLE;
                end
            end

            default: begin
                state_next = AES_ST_IDLE;
            end
        endcase

        // The reset state is IDLE, so in_ready must be masked explicitly.
        if (!reset_n) begin
            bus.in_ready = 1'b0;
        end

        accept = bus.in_valid && bus.in_ready;
        if (accept) begin
            work_next  = bus.in_block;
            cnt_next   = '0;
            state_next = AES_ST_SUB;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= AES_ST_IDLE;
            cnt   <= '0;
            // NOTE: the work register is reset along with the FSM so a block
            // discarded by reset can never resurface on out_block.
            work  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            work  <= work_next;
        end
    end

endmodule

// File: tb/tb_aes_inv_sbox_unit.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_sbox_unit
// Three instances (LANES = 4, 1, 16) share one clock and reset; one instance
// is exercised at a time (sel). Expected blocks go into a scoreboard queue as
// they are offered; a monitor pops and compares each one when it is handed off
// and checks acceptance-to-out_valid latency against NCYC. The reference
// InvSbox table is derived from GF(2^8) inversion plus the forward affine map.
// ---------------------------------------------------------------------------
module tb_aes_inv_sbox_unit;
    import aes_pkg::*;

    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic         iv   [NDUT];
    logic [127:0] ib   [NDUT];
    logic         ordy [NDUT];
    logic         ir   [NDUT];
    logic         ov   [NDUT];
    logic [127:0] ob   [NDUT];
    logic         bz   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : 16;
        aes_inv_sbox_unit_if bus ();
        assign bus.in_valid  = iv[g];
        assign bus.in_block  = ib[g];
        assign bus.out_ready = ordy[g];
        assign ir[g] = bus.in_ready;
        assign ov[g] = bus.out_valid;
        assign ob[g] = bus.out_block;
        aes_inv_sbox_unit #(.LANES(L)) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus),
            .busy    (bz[g])
        );
    end

    int           sel = 0;
    int           n_checks = 0;
    int           n_pass = 0;
    int           cyc = 0;
    logic [127:0] exp_q [$];
    int           acc_q [$];
    logic [7:0]   inv_tab [256];
    bit           in_hold = 1'b0;
    int           rise_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lanes_of(input int s);
        return (s == 0) ? 4 : (s == 1) ? 1 : 16;
    endfunction

    function automatic int ncyc_of(input int s);
        return 16 / lanes_of(s);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_table();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] xb, b, s;
            xb = 8'(x);
            b  = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (gmul(xb, 8'(y)) == 8'h01) b = 8'(y);
                end
            end
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            inv_tab[s] = xb;
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] blk);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = inv_tab[blk[127-8*i -: 8]];
        return r;
    endfunction

    // Scoreboard monitor: mid-cycle sampling, handshakes complete at the next edge.
    always @(negedge clk) begin
        if (!reset_n) begin
            in_hold = 1'b0;
        end else begin
            if (ov[sel]) begin
                if (!in_hold) begin
                    rise_cyc = cyc;
                    in_hold  = 1'b1;
                end
                if (ordy[sel]) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL spurious_output lanes=%0d got=%h required=no output", lanes_of(sel), ob[sel]);
                    end else begin
                        logic [127:0] e;
                        e = exp_q.pop_front();
                        if (ob[sel] !== e)
                            $display("FAIL out_block lanes=%0d got=%h required=%h", lanes_of(sel), ob[sel], e);
                        else
                            n_pass++;
                    end
                    if (acc_q.size() != 0) begin
                        int lat;
                        lat = rise_cyc - acc_q.pop_front();
                        n_checks++;
                        if (lat !== ncyc_of(sel))
                            $display("FAIL latency lanes=%0d got=%0d required=%0d", lanes_of(sel), lat, ncyc_of(sel));
                        else
                            n_pass++;
                    end
                    in_hold = 1'b0;
                end
            end else begin
                in_hold = 1'b0;
            end
            if (iv[sel] && ir[sel]) acc_q.push_back(cyc + 1);
        end
    end

    task automatic idle_all();
        for (int g = 0; g < NDUT; g++) begin
            iv[g] = 1'b0; ib[g] = '0; ordy[g] = 1'b1;
        end
    endtask

    // Offer blk until accepted; returns the accepting edge index.
    task automatic send(input logic [127:0] blk, input logic [127:0] expv, output int acc);
        int waited;
        waited = 0;
        acc    = -1;
        iv[sel] = 1'b1;
        ib[sel] = blk;
        exp_q.push_back(expv);
        while (acc < 0 && waited < 200) begin
            @(negedge clk);
            if (ir[sel]) acc = cyc + 1;
            waited++;
            @(posedge clk); #2;
        end
        iv[sel] = 1'b0;
        n_checks++;
        if (acc < 0) $display("FAIL accept_timeout lanes=%0d got=no in_ready required=accept within 200 cycles", lanes_of(sel));
        else n_pass++;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk); #2;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL drain_timeout lanes=%0d got=%0d pending required=0", lanes_of(sel), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_all();
        #3;
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (ir[g] !== 1'b0) $display("FAIL reset_in_ready dut=%0d got=%b required=0", g, ir[g]); else n_pass++;
            n_checks++; if (ov[g] !== 1'b0) $display("FAIL reset_out_valid dut=%0d got=%b required=0", g, ov[g]); else n_pass++;
            n_checks++; if (ob[g] !== '0) $display("FAIL reset_out_block dut=%0d got=%h required=0", g, ob[g]); else n_pass++;
            n_checks++; if (bz[g] !== 1'b0) $display("FAIL reset_busy dut=%0d got=%b required=0", g, bz[g]); else n_pass++;
        end
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
            n_checks++; if (ir[g] !== 1'b1) $display("FAIL idle_in_ready dut=%0d got=%b required=1", g, ir[g]); else n_pass++;
        end
        @(posedge clk); #2;
    endtask

    task automatic test_zero();
        int acc;
        ordy[sel] = 1'b1;
        send(128'h0, {16{8'h52}}, acc);
        @(negedge clk);
        n_checks++; if (bz[sel] !== 1'b1) $display("FAIL sub_busy lanes=%0d got=%b required=1", lanes_of(sel), bz[sel]); else n_pass++;
        n_checks++; if (ov[sel] !== 1'b0) $display("FAIL sub_out_valid lanes=%0d got=%b required=0", lanes_of(sel), ov[sel]); else n_pass++;
        @(posedge clk); #2;
        drain();
    endtask

    task automatic test_vector();
        int acc;
        send(128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb, acc);
        drain();
    endtask

    task automatic test_back_to_back();
        int a1, a2;
        ordy[sel] = 1'b1;
        send({16{8'h63}}, 128'h0, a1);
        send({16{8'hff}}, {16{8'h7d}}, a2);
        n_checks++;
        if (a2 - a1 !== ncyc_of(sel) + 1)
            $display("FAIL b2b_period lanes=%0d got=%0d required=%0d", lanes_of(sel), a2 - a1, ncyc_of(sel) + 1);
        else
            n_pass++;
        drain();
    endtask

    task automatic test_random(input int count);
        int acc;
        for (int i = 0; i < count; i++) begin
            logic [127:0] blk;
            blk = {$urandom, $urandom, $urandom, $urandom};
            send(blk, model(blk), acc);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        end
        drain();
    endtask

    task automatic test_stall();
        int acc, waited;
        logic [127:0] blk, e;
        blk = {$urandom, $urandom, $urandom, $urandom};
        e   = model(blk);
        ordy[sel] = 1'b0;
        send(blk, e, acc);
        waited = 0;
        @(negedge clk);
        while (!ov[sel] && waited < 50) begin @(negedge clk); waited++; end
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (ov[sel] !== 1'b1) $display("FAIL stall_out_valid cycle=%0d got=%b required=1", i, ov[sel]); else n_pass++;
            n_checks++; if (ob[sel] !== e) $display("FAIL stall_out_block cycle=%0d got=%h required=%h", i, ob[sel], e); else n_pass++;
            n_checks++; if (ir[sel] !== 1'b0) $display("FAIL stall_in_ready cycle=%0d got=%b required=0", i, ir[sel]); else n_pass++;
            @(posedge clk); #2;
            iv[sel] = (i % 2 == 0);
            ib[sel] = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
        end
        @(posedge clk); #2;
        iv[sel]   = 1'b0;
        ordy[sel] = 1'b1;
        @(negedge clk);
        @(posedge clk); #2;
        @(negedge clk);
        n_checks++; if (ov[sel] !== 1'b0) $display("FAIL post_stall_out_valid got=%b required=0", ov[sel]); else n_pass++;
        n_checks++; if (ir[sel] !== 1'b1) $display("FAIL post_stall_in_ready got=%b required=1", ir[sel]); else n_pass++;
        n_checks++; if (bz[sel] !== 1'b0) $display("FAIL post_stall_busy got=%b required=0", bz[sel]); else n_pass++;
        n_checks++; if (exp_q.size() !== 0) $display("FAIL post_stall_pending got=%0d required=0", exp_q.size()); else n_pass++;
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid();
        int acc;
        logic [127:0] blk;
        ordy[sel] = 1'b1;
        send({16{8'ha5}}, model({16{8'ha5}}), acc);
        @(posedge clk); #2;
        reset_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        n_checks++; if (ov[sel] !== 1'b0) $display("FAIL midreset_out_valid got=%b required=0", ov[sel]); else n_pass++;
        n_checks++; if (ob[sel] !== '0) $display("FAIL midreset_out_block got=%h required=0", ob[sel]); else n_pass++;
        n_checks++; if (bz[sel] !== 1'b0) $display("FAIL midreset_busy got=%b required=0", bz[sel]); else n_pass++;
        n_checks++; if (ir[sel] !== 1'b0) $display("FAIL midreset_in_ready got=%b required=0", ir[sel]); else n_pass++;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        n_checks++; if (ir[sel] !== 1'b1) $display("FAIL postreset_in_ready got=%b required=1", ir[sel]); else n_pass++;
        n_checks++; if (ov[sel] !== 1'b0) $display("FAIL postreset_out_valid got=%b required=0", ov[sel]); else n_pass++;
        @(posedge clk); #2;
        blk = 128'h3d4c5b6a798897a6b5c4d3e2f1001f2e;
        send(blk, model(blk), acc);
        drain();
    endtask

    initial begin
        build_table();
        test_reset();
        for (int s = 0; s < NDUT; s++) begin
            sel = s;
            test_zero();
            test_vector();
            test_back_to_back();
            test_random(3);
        end
        sel = 0;
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
